sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-port, pipelined synchronous SRAM between the CPU's instruction-fetch port and data-memory port. Accepts at most one access per cycle. Data requests win by default. A streak counter bounds instruction-fetch starvation. A tag delay line routes each read return to its owner. Sits between the Mips core's fetch/memory stages and the unified SRAM in single-memory SoC builds.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from the issue edge to valid `sram_rdata` (1..4)
- MAX_STREAK, 4, consecutive data grants tolerated while fetch waits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_wen  in  4  byte write enables; 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  data accepted this cycle
- d_rvalid  out  1  data read valid
- d_rdata  out  DATA_W  data read data
- sram_en  out  1  SRAM access enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data

## Operation
- Grant is combinational each cycle:
  - Only one requester high: that requester wins.
  - Both high: data wins, unless `streak == MAX_STREAK`; then fetch wins.
  - Neither high: no grant; `sram_en=0`, `sram_wen=0`.
- Winner's fields drive `sram_*` directly. Fetch grant drives `sram_wen=0` and `sram_wdata=0`. The matching `*_ack` is 1 in the same cycle. The loser's ack is 0, and it must hold its request and fields.
- Streak counter (width `clog2(MAX_STREAK+1)`):
  - Data grant while `i_req=1`: increment, saturating at MAX_STREAK.
  - Fetch grant, or `i_req=0`: clear.
- Tag delay line: RD_LAT stages of {valid, owner}, where owner ∈ {NONE, I, D}.
  - Stage 0 loads `owner=I` on a fetch grant, `owner=D` on a data read grant, and NONE otherwise. Data writes load NONE.
  - Final stage drives `i_rvalid` (owner I) or `d_rvalid` (owner D).
  - `i_rdata` and `d_rdata` both pass `sram_rdata` through unconditionally. Consumers qualify with rvalid.
- A new issue and an older read's return in the same cycle are independent and both occur.
- No back-pressure on returns: requesters always accept rvalid.

## Timing
- Issue in cycle T → `*_ack=1` in T; SRAM samples at the end of T.
- Read data: `*_rvalid=1` in cycle T+RD_LAT, for exactly one cycle.
- Throughput: one access per cycle, reads and writes freely interleaved.
- Reset (asynchronous, any time):
  - All tag stages cleared to NONE and streak cleared to 0.
  - `i_rvalid=0` and `d_rvalid=0` while `rst=1`. Reads in flight at reset are dropped, with no rvalid afterwards.
  - `sram_en`, `sram_wen`, and acks follow the grant logic, but requesters are held low by the core during reset, so these outputs are 0.
- First cycle after reset deassertion: normal arbitration.
- Starvation bound: with `d_req` held high continuously, a pending fetch is granted within MAX_STREAK+1 cycles.

## Structure
- Package `sram_arb_pkg`:
  - owner enum `OWN_NONE`, `OWN_I`, `OWN_D`
  - tag struct {valid, owner}
  - default parameter constants
- Sub-module `arb_tag_pipe`: parameterised RD_LAT-deep tag shift register with asynchronous clear. Grant logic and streak counter stay in the top.

## Test plan
- **Fetch only**: `i_req=1`, `i_addr=0xBFC00000`, RD_LAT=1, SRAM returns 0x3C1D0001 → `i_ack=1` in T, `sram_addr=0xBFC00000`, `sram_wen=0`; `i_rvalid=1` with `i_rdata=0x3C1D0001` in T+1.
- **Data write vs fetch**: both request, `d_wen=4'b0011`, `d_addr=0x80000010`, `d_wdata=0xDEADBEEF` →
  - `d_ack=1`, `i_ack=0`, `sram_wen=4'b0011`;
  - fetch granted next cycle;
  - no rvalid for the write.
- **Starvation**: MAX_STREAK=4, `d_req` and `i_req` held high, data reads → 4 data acks, then `i_ack=1` in cycle 5, then data wins again with streak restarted.
- **Back-to-back mixed reads**: RD_LAT=2, fetch at T, data read at T+1, fetch at T+2 →
  - `i_rvalid` at T+2;
  - `d_rvalid` at T+3;
  - `i_rvalid` at T+4;
  - never both rvalids high in one cycle.
- **Reset mid-flight**: RD_LAT=3, data read issued, `rst` asserted asynchronously one cycle later → `d_rvalid` stays 0 through and after reset; streak reads 0.
- **Idle**: no requests for 10 cycles → `sram_en=0`, acks 0, rvalids 0 every cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: owner enum, tag record and default parameters shared by the SRAM port arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_MAX_STREAK = 4;
endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: RD_LAT-deep {valid, owner} shift register (clk, async rst, tag_in -> tag_out) matching SRAM read latency
module arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t stage [RD_LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int k = 1; k < RD_LAT; k++) stage[k] <= stage[k-1];
    end
  end
  assign tag_out = stage[RD_LAT-1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: fetch (i_*) and data (d_*) ports share one pipelined SRAM (sram_*); data wins unless fetch has waited MAX_STREAK grants, tags route read returns
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak;
  logic          gnt_i, gnt_d, rd_d, full;
  tag_t          tag_in, tag_out;
  assign full       = streak == SW'(MAX_STREAK);
  assign gnt_i      = i_req && (!d_req || full);
  assign gnt_d      = d_req && !gnt_i;
  assign rd_d       = gnt_d && d_wen == 4'b0;
  assign i_ack      = gnt_i;
  assign d_ack      = gnt_d;
  assign sram_en    = gnt_i || gnt_d;
  assign sram_wen   = gnt_d ? d_wen : 4'b0;
  assign sram_addr  = gnt_i ? i_addr : d_addr;
  assign sram_wdata = gnt_d ? d_wdata : '0;
  assign tag_in     = '{valid: gnt_i || rd_d, owner: gnt_i ? OWN_I : rd_d ? OWN_D : OWN_NONE};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak <= '0;
    else     streak <= (gnt_d && i_req) ? (full ? streak : streak + 1'b1) : '0;
  end
  arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );
  assign i_rvalid = tag_out.valid && tag_out.owner == OWN_I;
  assign d_rvalid = tag_out.valid && tag_out.owner == OWN_D;
  assign i_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table-driven grant checks plus latency/reset sequences on RD_LAT=1,2,3 instances
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [3:0]  d_wen = 4'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, sram_rdata = '0;
  logic        i_ack [3], d_ack [3], i_rvalid [3], d_rvalid [3], sram_en [3];
  logic [3:0]  sram_wen [3];
  logic [31:0] i_rdata [3], d_rdata [3], sram_addr [3], sram_wdata [3];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_port_arbiter #(.RD_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack[g]),
      .i_rvalid  (i_rvalid[g]),
      .i_rdata   (i_rdata[g]),
      .d_req     (d_req),
      .d_wen     (d_wen),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .sram_en   (sram_en[g]),
      .sram_wen  (sram_wen[g]),
      .sram_addr (sram_addr[g]),
      .sram_wdata(sram_wdata[g]),
      .sram_rdata(sram_rdata)
    );
  end

  typedef struct {
    logic        ir, dr;
    logic [3:0]  wen;
    logic [31:0] ia, da, dw;
    logic        ei, ed;
    logic [3:0]  ewen;
    logic [31:0] ea, ew;
  } vec_t;
  vec_t v [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic [3:0] wen,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw);
    @(posedge clk);
    #1;
    i_req = ir; d_req = dr; d_wen = wen; i_addr = ia; d_addr = da; d_wdata = dw;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 4'h0, '0, '0, '0);
  endtask

  initial begin
    logic ei_c [6], ed_c [6];
    v[0]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 4'h0, 32'h0,        32'h0};
    v[1]  = '{1'b1, 1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h0,        1'b1, 1'b0, 4'h0, 32'hBFC00000, 32'h0};
    v[2]  = '{1'b0, 1'b1, 4'h3, 32'h0,        32'h80000010, 32'hDEADBEEF, 1'b0, 1'b1, 4'h3, 32'h80000010, 32'hDEADBEEF};
    v[3]  = '{1'b1, 1'b1, 4'h3, 32'hBFC00004, 32'h80000010, 32'hDEADBEEF, 1'b0, 1'b1, 4'h3, 32'h80000010, 32'hDEADBEEF};
    v[4]  = '{1'b1, 1'b1, 4'h0, 32'hBFC00004, 32'h80000020, 32'h0,        1'b0, 1'b1, 4'h0, 32'h80000020, 32'h0};
    v[5]  = v[4];
    v[6]  = v[4];
    v[7]  = '{1'b1, 1'b1, 4'h0, 32'hBFC00004, 32'h80000024, 32'h12345678, 1'b1, 1'b0, 4'h0, 32'hBFC00004, 32'h0};
    v[8]  = '{1'b1, 1'b1, 4'h0, 32'hBFC00004, 32'h80000024, 32'h0,        1'b0, 1'b1, 4'h0, 32'h80000024, 32'h0};
    v[9]  = '{1'b0, 1'b1, 4'h0, 32'h0,        32'h80000028, 32'h0,        1'b0, 1'b1, 4'h0, 32'h80000028, 32'h0};
    v[10] = '{1'b1, 1'b1, 4'h0, 32'hBFC00008, 32'h8000002C, 32'h0,        1'b0, 1'b1, 4'h0, 32'h8000002C, 32'h0};
    v[11] = v[10];
    v[12] = v[10];
    v[13] = v[10];
    v[14] = '{1'b1, 1'b1, 4'h0, 32'hBFC00008, 32'h8000002C, 32'h0,        1'b1, 1'b0, 4'h0, 32'hBFC00008, 32'h0};
    ei_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ed_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #12;
    for (int g = 0; g < 3; g++) begin
      chk("reset i_rvalid", 32'(i_rvalid[g]), 32'h0);
      chk("reset d_rvalid", 32'(d_rvalid[g]), 32'h0);
      chk("reset sram_en", 32'(sram_en[g]), 32'h0);
    end
    #1 rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      idle(1);
      @(negedge clk);
      chk("idle sram_en", 32'(sram_en[0]), 32'h0);
      chk("idle acks", {30'h0, i_ack[0], d_ack[0]}, 32'h0);
      for (int g = 0; g < 3; g++) chk("idle rvalids", {30'h0, i_rvalid[g], d_rvalid[g]}, 32'h0);
    end

    foreach (v[n]) begin
      drive(v[n].ir, v[n].dr, v[n].wen, v[n].ia, v[n].da, v[n].dw);
      @(negedge clk);
      chk($sformatf("vec%0d i_ack", n), 32'(i_ack[0]), 32'(v[n].ei));
      chk($sformatf("vec%0d d_ack", n), 32'(d_ack[0]), 32'(v[n].ed));
      chk($sformatf("vec%0d sram_en", n), 32'(sram_en[0]), 32'(v[n].ei | v[n].ed));
      chk($sformatf("vec%0d sram_wen", n), 32'(sram_wen[0]), 32'(v[n].ewen));
      if (v[n].ei | v[n].ed) begin
        chk($sformatf("vec%0d sram_addr", n), sram_addr[0], v[n].ea);
        chk($sformatf("vec%0d sram_wdata", n), sram_wdata[0], v[n].ew);
      end
    end

    idle(4);
    drive(1'b1, 1'b0, 4'h0, 32'hBFC00000, '0, '0);
    @(negedge clk);
    chk("fetch i_ack", 32'(i_ack[0]), 32'h1);
    chk("fetch d_ack", 32'(d_ack[0]), 32'h0);
    chk("fetch sram_addr", sram_addr[0], 32'hBFC00000);
    chk("fetch sram_wen", 32'(sram_wen[0]), 32'h0);
    drive(1'b0, 1'b0, 4'h0, '0, '0, '0);
    sram_rdata = 32'h3C1D0001;
    @(negedge clk);
    chk("fetch i_rvalid", 32'(i_rvalid[0]), 32'h1);
    chk("fetch i_rdata", i_rdata[0], 32'h3C1D0001);
    chk("fetch d_rvalid", 32'(d_rvalid[0]), 32'h0);
    idle(1);
    @(negedge clk);
    chk("fetch i_rvalid one cycle", 32'(i_rvalid[0]), 32'h0);

    idle(4);
    drive(1'b1, 1'b1, 4'h3, 32'hBFC00010, 32'h80000010, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr d_ack", 32'(d_ack[0]), 32'h1);
    chk("wr i_ack", 32'(i_ack[0]), 32'h0);
    chk("wr sram_wen", 32'(sram_wen[0]), 32'h3);
    drive(1'b1, 1'b0, 4'h0, 32'hBFC00010, '0, '0);
    @(negedge clk);
    chk("wr then fetch i_ack", 32'(i_ack[0]), 32'h1);
    chk("wr no d_rvalid", 32'(d_rvalid[0]), 32'h0);
    chk("wr no i_rvalid", 32'(i_rvalid[0]), 32'h0);
    idle(1);
    @(negedge clk);
    chk("wr fetch i_rvalid", 32'(i_rvalid[0]), 32'h1);
    chk("wr fetch d_rvalid", 32'(d_rvalid[0]), 32'h0);

    idle(4);
    for (int c = 0; c < 6; c++) begin
      drive(c == 0 || c == 2, c == 1, 4'h0, 32'hBFC00020, 32'h80000030, '0);
      @(negedge clk);
      chk($sformatf("mix c%0d i_rvalid", c), 32'(i_rvalid[1]), 32'(ei_c[c]));
      chk($sformatf("mix c%0d d_rvalid", c), 32'(d_rvalid[1]), 32'(ed_c[c]));
      chk($sformatf("mix c%0d both", c), 32'(i_rvalid[1] & d_rvalid[1]), 32'h0);
    end

    idle(4);
    drive(1'b1, 1'b1, 4'hF, 32'hBFC00040, 32'h80000040, 32'h11111111);
    drive(1'b1, 1'b1, 4'hF, 32'hBFC00040, 32'h80000044, 32'h22222222);
    drive(1'b1, 1'b1, 4'h0, 32'hBFC00040, 32'h80000048, '0);
    @(negedge clk);
    chk("rst pre d_ack", 32'(d_ack[2]), 32'h1);
    drive(1'b0, 1'b0, 4'h0, '0, '0, '0);
    #1 rst = 1'b1;
    #1;
    chk("rst d_rvalid during", 32'(d_rvalid[2]), 32'h0);
    chk("rst i_rvalid during", 32'(i_rvalid[2]), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst d_rvalid after c0", 32'(d_rvalid[2]), 32'h0);
    for (int c = 1; c < 4; c++) begin
      idle(1);
      @(negedge clk);
      chk($sformatf("rst d_rvalid after c%0d", c), 32'(d_rvalid[2]), 32'h0);
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 4'h0, 32'hBFC00050, 32'h80000050, '0);
      @(negedge clk);
      chk($sformatf("streak c%0d i_ack", c), 32'(i_ack[2]), 32'(c == 4));
      chk($sformatf("streak c%0d d_ack", c), 32'(d_ack[2]), 32'(c != 4));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
